spi_reg_rx: RTL and testbench
=============================

# spi_reg_rx

Parametrised SPI-slave register receiver, the successor of the single-byte SPI deserializer that feeds the lamp's colour/PWM pipeline. It runs in the `clk` domain and oversamples the asynchronous `sck`/`cs`/`mosi` pins through synchronizers. Each frame carries a start address followed by data words. Words auto-increment into a register bank that is committed atomically when `cs` deasserts. The block replaces the separate deserializer plus dispenser pair: colour, mode and white registers come straight out of `regs`.

## Interface
Parameters:
- `DATA_W`, 8: bits per SPI word (address and data words alike); ≥ 4.
- `NUM_REGS`, 7: register count (lint, red, green, blue, colorIdx, white, mode).
- `SYNC_STAGES`, 2: flip-flops per input synchronizer; ≥ 2.
- `ATOMIC`, 1: 1 = shadow bank, copy on clean frame end; 0 = write live bank per word.

Ports:
- `clk`  in  1  system clock. One clock domain; all logic samples on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sck`  in  1  SPI clock, asynchronous. Mode 0: data sampled on the rising edge.
- `cs`  in  1  chip select, active low, asynchronous.
- `mosi`  in  1  serial data, asynchronous, MSB first.
- `regs`  out  NUM_REGS*DATA_W  flattened live bank; reg i is at `[i*DATA_W +: DATA_W]`.
- `word_data`  out  DATA_W  last complete word received.
- `word_rdy`  out  1  1-cycle pulse when `word_data` updates.
- `frame_done`  out  1  1-cycle pulse at the end of a frame.
- `frame_err`  out  1  error flag; stays valid from `frame_done` until the next frame starts.

## Operation
- Three synchronizers produce `sck_s`, `cs_s` and `mosi_s`. An edge detector on `sck_s` gives `sck_rise`, and one on `cs_s` gives `cs_fall` and `cs_rise`.
- FSM states: `IDLE`, `ADDR`, `DATA`, `DROP`.
  - IDLE → ADDR on `cs_fall`. This clears the bit counter, `frame_err` and `addr`; with `ATOMIC`=1 it also loads shadow ← live.
  - In ADDR or DATA, each `sck_rise` while `cs_s`=0 shifts `mosi_s` into the shift register at the LSB end. When the bit counter reaches `DATA_W`, the word is complete: `word_rdy` pulses and the counter clears.
  - ADDR on word complete: value < `NUM_REGS` → `addr` ← value, go to DATA. Otherwise → set `frame_err`, go to DROP.
  - DATA on word complete: `addr` < `NUM_REGS` → write the word to reg[addr] (shadow or live), then `addr`++. Otherwise (overrun past the last register) → discard the word, set `frame_err`, go to DROP.
  - In DROP, words keep shifting and `word_rdy` keeps pulsing, but nothing is written.
  - Any state except IDLE → IDLE on `cs_rise`.
    - If the bit counter is ≠ 0, the partial word is discarded and `frame_err` is set.
    - `frame_done` pulses. With `ATOMIC`=1: live ← shadow only if `frame_err`=0 after this update.
    - An address-only frame is legal: no error, and the live bank is unchanged.
- The address counter does not wrap: it saturates at `NUM_REGS`.
- `reset` dominates everything: FSM → IDLE, and all banks, counters and outputs → 0.
  - After a mid-frame reset the block stays in IDLE until the next `cs_fall`. The bits of the interrupted frame are ignored.
  - The live bank is not written by a frame interrupted by reset.

## Timing
- Reset values: `regs`=0, `word_data`=0, `word_rdy`=0, `frame_done`=0, `frame_err`=0.
- Latency from a raw `sck` rising edge to `sck_rise`: `SYNC_STAGES`+1 clk.
- `word_rdy`/`word_data` are registered one clk after the `sck_rise` of the last bit. Total latency is `SYNC_STAGES`+2 clk.
- The live `regs` word updates in the same cycle as `word_rdy` (`ATOMIC`=0). With `ATOMIC`=1 the whole bank updates in the cycle `frame_done` is high.
- `frame_done` comes `SYNC_STAGES`+2 clk after the raw `cs` rising edge.
- Simultaneous `sck_rise` and `cs_rise`: `cs_rise` wins and that bit is dropped.
- Input constraints:
  - `sck` high and low phases ≥ `SYNC_STAGES`+1 clk each.
  - `cs` deassertion ≥ `SYNC_STAGES`+2 clk.
  - `mosi` stable around the `sck` rising edge for ≥ 2 clk, so `mosi_s` aligns with `sck_rise`.

## Structure
- Package `spi_reg_pkg`:
  - state enum `spi_state_t` (IDLE/ADDR/DATA/DROP);
  - default constants `SPI_DATA_W`=8, `SPI_NUM_REGS`=7;
  - `ADDR_W` derived as `$clog2(NUM_REGS+1)` so the saturated value `NUM_REGS` is representable.
- Sub-module `spi_sync`: a `SYNC_STAGES`-deep synchronizer plus registered rise/fall detect, instantiated for `sck` and `cs`. `mosi` uses the same module with the edge outputs unused.

## Test plan
- Frame 0x01, 0xAA, 0xBB with `ATOMIC`=1 → 3 `word_rdy` pulses. On `frame_done`, reg1=0xAA, reg2=0xBB, others 0, `frame_err`=0. Regs stay unchanged before `cs_rise`.
- Frame 0x05, 0x11, 0x22, 0x33 (`NUM_REGS`=7) → reg5=0x11, reg6=0x22. The 0x33 is discarded, `frame_err`=1, and with `ATOMIC`=1 the live bank is unchanged.
- Address word 0x09 then 0x44 → `frame_err`=1, no register write, 2 `word_rdy` pulses.
- Frame 0x00, 0x5A, then `cs` raised after 3 bits of the next word → `frame_err`=1. With `ATOMIC`=1 reg0 keeps its prior value; with `ATOMIC`=0 reg0=0x5A.
- Assert `reset` for 1 clk after 12 bits of a frame 0x02, 0x77 → all outputs 0. The next clean frame 0x03, 0x99 gives reg3=0x99 and reg2=0.
- `ATOMIC`=0, frame 0x04, 0xC3 → reg4=0xC3 in the cycle `word_rdy` is high, measured `SYNC_STAGES`+2 clk after the 16th raw `sck` rising edge.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and defaults for the SPI register receiver.
// Holds the frame FSM state encoding and the address-width helper.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DROP
    } spi_state_t;

    localparam int SPI_DATA_W   = 8;
    localparam int SPI_NUM_REGS = 7;

    // One extra code point so the saturated address NUM_REGS fits.
    function automatic int spi_addr_w(input int num_regs);
        return $clog2(num_regs + 1);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage input synchronizer with registered rise/fall detection.
// The level output is delayed one extra flop so it lines up with the edge pulses.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            q     <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~q;
            fall  <= ~chain[STAGES-1] & q;
        end
    end

endmodule

// File: rtl/spi_reg_rx.sv
// SPI mode-0 slave that receives an address word followed by auto-incrementing
// data words into a register bank, optionally committed atomically at frame end.
module spi_reg_rx
    import spi_reg_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int NUM_REGS    = SPI_NUM_REGS,
    parameter int SYNC_STAGES = 2,
    parameter int ATOMIC      = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sck,
    input  logic                       cs,
    input  logic                       mosi,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic [DATA_W-1:0]          word_data,
    output logic                       word_rdy,
    output logic                       frame_done,
    output logic                       frame_err
);

    localparam int ADDR_W = spi_addr_w(NUM_REGS);
    localparam int CNT_W  = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT  = ADDR_W'(NUM_REGS);
    localparam logic [DATA_W:0]   WORD_LIMIT  = (DATA_W + 1)'(NUM_REGS);

    logic sck_s_unused, sck_rise, sck_fall_unused;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk  (clk),
        .reset(reset),
        .din  (sck),
        .q    (sck_s_unused),
        .rise (sck_rise),
        .fall (sck_fall_unused)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk  (clk),
        .reset(reset),
        .din  (cs),
        .q    (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk  (clk),
        .reset(reset),
        .din  (mosi),
        .q    (mosi_s),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    spi_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shift;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] live   [NUM_REGS];
    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] word_next;
    logic              word_in_range;

    always_comb begin
        word_next     = {shift, mosi_s};
        word_in_range = ({1'b0, word_next} < WORD_LIMIT);
    end

    always_comb begin
        regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i*DATA_W +: DATA_W] = live[i];
        end
    end

    // cs_rise takes priority over a coincident sck_rise, dropping that bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            addr       <= '0;
            word_data  <= '0;
            word_rdy   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            word_rdy   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= ADDR;
                        bit_cnt   <= '0;
                        addr      <= '0;
                        frame_err <= 1'b0;
                        if (ATOMIC != 0) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                shadow[i] <= live[i];
                            end
                        end
                    end
                end
                default: begin
                    if (cs_rise) begin
                        state      <= IDLE;
                        bit_cnt    <= '0;
                        frame_done <= 1'b1;
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                        if (ATOMIC != 0 && !frame_err && bit_cnt == '0) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                live[i] <= shadow[i];
                            end
                        end
                    end else if (sck_rise && !cs_s) begin
                        shift <= word_next[DATA_W-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            word_data <= word_next;
                            word_rdy  <= 1'b1;
                            if (state == ADDR) begin
                                if (word_in_range) begin
                                    addr  <= ADDR_W'(word_next);
                                    state <= DATA;
                                end else begin
                                    frame_err <= 1'b1;
                                    state     <= DROP;
                                end
                            end else if (state == DATA) begin
                                if (addr < ADDR_LIMIT) begin
                                    for (int i = 0; i < NUM_REGS; i++) begin
                                        if (addr == ADDR_W'(i)) begin
                                            if (ATOMIC != 0) begin
                                                shadow[i] <= word_next;
                                            end else begin
                                                live[i] <= word_next;
                                            end
                                        end
                                    end
                                    addr <= addr + ADDR_W'(1);
                                end else begin
                                    frame_err <= 1'b1;
                                    state     <= DROP;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_rx.sv
// Scoreboard bench for spi_reg_rx: one atomic and one live-write instance share
// the same SPI pins and are checked against a small frame-level model.
module tb_spi_reg_rx;

    localparam int DW = 8;
    localparam int NR = 7;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic reset, sck, cs, mosi;

    logic [NR*DW-1:0] regs_a, regs_l;
    logic [DW-1:0]    word_data_a, word_data_l;
    logic             word_rdy_a, word_rdy_l;
    logic             frame_done_a, frame_done_l;
    logic             frame_err_a, frame_err_l;

    typedef struct {
        logic [7:0]       word;
        logic [NR*DW-1:0] regs_l;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] frame_words[$];
    logic [7:0] exp_a  [NR];
    logic [7:0] exp_l  [NR];
    logic [7:0] shadow [NR];

    int  tests_run    = 0;
    int  tests_failed = 0;
    time rise_time    = 0;

    always #5 clk = ~clk;

    spi_reg_rx #(.DATA_W(DW), .NUM_REGS(NR), .SYNC_STAGES(SS), .ATOMIC(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .cs        (cs),
        .mosi      (mosi),
        .regs      (regs_a),
        .word_data (word_data_a),
        .word_rdy  (word_rdy_a),
        .frame_done(frame_done_a),
        .frame_err (frame_err_a)
    );

    spi_reg_rx #(.DATA_W(DW), .NUM_REGS(NR), .SYNC_STAGES(SS), .ATOMIC(0)) dut_l (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .cs        (cs),
        .mosi      (mosi),
        .regs      (regs_l),
        .word_data (word_data_l),
        .word_rdy  (word_rdy_l),
        .frame_done(frame_done_l),
        .frame_err (frame_err_l)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] pack(input logic [7:0] b [NR]);
        logic [NR*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = b[i];
        return r;
    endfunction

    // Every word_rdy must match the oldest pending expectation, arrive
    // SS+2 clocks after the last raw sck edge, and (live bank) carry the write.
    always @(negedge clk) begin
        if (word_rdy_l) begin
            if (sb.size() == 0) begin
                checkOutput("sb_extra", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("word_data_l", word_data_l, e.word);
                checkOutput("word_data_a", word_data_a, e.word);
                checkOutput("word_rdy_a", word_rdy_a, 1);
                checkOutput("regs_live_word", regs_l, e.regs_l);
                checkOutput("rdy_latency", $time - rise_time, 10 * (SS + 2));
            end
        end
    end

    task automatic sendBits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sck  = 1'b0;
            mosi = v[7-i];
            repeat (3) @(negedge clk);
            @(negedge clk);
            sck       = 1'b1;
            rise_time = $time;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic endFrame(input logic err);
        int k;
        @(negedge clk);
        cs = 1'b1;
        k  = 0;
        while (k < 20 && !frame_done_a) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_latency", k, SS + 2);
        checkOutput("done_l", frame_done_l, 1);
        checkOutput("regs_atomic", regs_a, pack(exp_a));
        checkOutput("regs_live", regs_l, pack(exp_l));
        checkOutput("err_a", frame_err_a, err);
        checkOutput("err_l", frame_err_l, err);
        @(negedge clk);
        checkOutput("done_pulse", frame_done_a, 0);
        checkOutput("err_hold", frame_err_a, err);
        checkOutput("sb_empty", sb.size(), 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic applyStimulus(input int pn, input logic [7:0] pv);
        int   a;
        logic err;
        exp_t e;
        shadow = exp_a;
        err    = 1'b0;
        a      = 0;
        foreach (frame_words[i]) begin
            if (i == 0) begin
                if (int'(frame_words[0]) < NR) a = int'(frame_words[0]);
                else err = 1'b1;
            end else if (!err) begin
                if (a < NR) begin
                    shadow[a] = frame_words[i];
                    exp_l[a]  = frame_words[i];
                    a++;
                end else begin
                    err = 1'b1;
                end
            end
            e.word   = frame_words[i];
            e.regs_l = pack(exp_l);
            sb.push_back(e);
        end
        if (pn > 0) err = 1'b1;

        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("err_clear", frame_err_a, 0);
        foreach (frame_words[i]) sendBits(frame_words[i], 8);
        if (pn > 0) sendBits(pv, pn);
        @(negedge clk);
        sck = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("regs_hold", regs_a, pack(exp_a));
        if (!err) exp_a = shadow;
        endFrame(err);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: run did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;
        exp_t e;
        reset = 1'b1;
        sck   = 1'b0;
        cs    = 1'b1;
        mosi  = 1'b0;
        for (int i = 0; i < NR; i++) begin
            exp_a[i] = '0;
            exp_l[i] = '0;
        end
        repeat (3) @(negedge clk);
        checkOutput("rst_regs", regs_a, 0);
        checkOutput("rst_word_data", word_data_a, 0);
        checkOutput("rst_word_rdy", word_rdy_a, 0);
        checkOutput("rst_frame_done", frame_done_a, 0);
        checkOutput("rst_frame_err", frame_err_a, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        frame_words = '{8'h01, 8'hAA, 8'hBB};
        applyStimulus(0, 8'h00);
        frame_words = '{8'h00, 8'h12};
        applyStimulus(0, 8'h00);
        frame_words = '{8'h00, 8'h5A};
        applyStimulus(3, 8'hE0);
        frame_words = '{8'h05, 8'h11, 8'h22, 8'h33};
        applyStimulus(0, 8'h00);
        frame_words = '{8'h09, 8'h44};
        applyStimulus(0, 8'h00);

        // Reset in the middle of a frame: 12 bits of 0x02, 0x77.
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        e.word   = 8'h02;
        e.regs_l = pack(exp_l);
        sb.push_back(e);
        sendBits(8'h02, 8);
        sendBits(8'h77, 4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            exp_a[i] = '0;
            exp_l[i] = '0;
        end
        checkOutput("mid_rst_regs_a", regs_a, 0);
        checkOutput("mid_rst_regs_l", regs_l, 0);
        checkOutput("mid_rst_word_data", word_data_a, 0);
        checkOutput("mid_rst_word_rdy", word_rdy_a, 0);
        checkOutput("mid_rst_frame_done", frame_done_a, 0);
        checkOutput("mid_rst_frame_err", frame_err_a, 0);
        checkOutput("mid_rst_sb", sb.size(), 0);
        @(negedge clk);
        sck = 1'b0;
        repeat (3) @(negedge clk);
        cs   = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (frame_done_a || frame_done_l) seen = 1'b1;
        end
        checkOutput("no_done_after_rst", seen, 0);

        frame_words = '{8'h03, 8'h99};
        applyStimulus(0, 8'h00);
        frame_words = '{8'h04, 8'hC3};
        applyStimulus(0, 8'h00);
        frame_words = '{8'h02};
        applyStimulus(0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
